// File: rtl/booth_arb_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
//   state_e      : arbiter FSM state encoding
//   clog2()      : index width helper (never returns less than 1)
//   *_DEF        : default parameter values
package booth_arb_pkg;

  localparam int unsigned N_DEF       = 4;
  localparam int unsigned W_DEF       = 4;
  localparam int unsigned TIMEOUT_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Bits needed to index v items; a single item still gets one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals of the arbiter.
//   req/req_x/req_y            : requester requests and packed operands
//   ack/rsp_z/rsp_err          : per-requester ack pulse and shared response
//   busy                       : arbiter not idle
//   mul_start/mul_x/mul_y      : multiplier command
//   mul_valid/mul_z            : multiplier result
// slave  : seen by the arbiter
// master : seen by the environment (requesters plus multiplier)
interface booth_mul_arbiter_if
  import booth_arb_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
);

  logic [N-1:0]   req;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   ack;
  logic [2*W-1:0] rsp_z;
  logic           rsp_err;
  logic           busy;
  logic           mul_start;
  logic [W-1:0]   mul_x;
  logic [W-1:0]   mul_y;
  logic           mul_valid;
  logic [2*W-1:0] mul_z;

  modport slave (
    input  req, req_x, req_y, mul_valid, mul_z,
    output ack, rsp_z, rsp_err, busy, mul_start, mul_x, mul_y
  );

  modport master (
    output req, req_x, req_y, mul_valid, mul_z,
    input  ack, rsp_z, rsp_err, busy, mul_start, mul_x, mul_y
  );

endinterface

// File: rtl/rr_select.sv
// Rotating-priority pick: first set request at or above rr_ptr, wrapping.
//   req_i         : request vector
//   rr_ptr_i      : index holding highest priority
//   gnt_valid_c_o : some request is set
//   gnt_idx_c_o   : chosen index (0 when nothing is set)
module rr_select
  import booth_arb_pkg::*;
#(
  parameter  int unsigned N  = N_DEF,
  localparam int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic          gnt_valid_c_o,
  output logic [IW-1:0] gnt_idx_c_o
);

  always_comb begin : pick
    int unsigned j;
    gnt_valid_c_o = 1'b0;
    gnt_idx_c_o   = '0;
    j             = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(rr_ptr_i) + k;
      if (j >= N) j = j - N;
      if (!gnt_valid_c_o && req_i[IW'(j)]) begin
        gnt_valid_c_o = 1'b1;
        gnt_idx_c_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one sequential Booth multiplier among N requesters, round robin,
// one multiply in flight. Issues a one-cycle start, waits for the result
// (with timeout) and returns it to the granted requester with a one-cycle ack.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester and multiplier signals (booth_mul_arbiter_if.slave)
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst,
  booth_mul_arbiter_if.slave bus
);

  localparam int unsigned IW = clog2(N);
  localparam int unsigned TW = clog2(TIMEOUT + 1);
  localparam int unsigned ZW = 2 * W;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [W-1:0]    mul_x_q, mul_x_d;
  logic [W-1:0]    mul_y_q, mul_y_d;
  logic            mul_start_q, mul_start_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [ZW-1:0]   rsp_z_q, rsp_z_d;
  logic            rsp_err_q, rsp_err_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            busy_q, busy_d;

  logic            gnt_valid_c;
  logic [IW-1:0]   gnt_idx_c;

  rr_select #(.N(N)) u_sel (
    .req_i         (bus.req),
    .rr_ptr_i      (rr_ptr_q),
    .gnt_valid_c_o (gnt_valid_c),
    .gnt_idx_c_o   (gnt_idx_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      mul_start_q <= 1'b0;
      timer_q     <= '0;
      rsp_z_q     <= '0;
      rsp_err_q   <= 1'b0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      mul_start_q <= mul_start_d;
      timer_q     <= timer_d;
      rsp_z_q     <= rsp_z_d;
      rsp_err_q   <= rsp_err_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; start and ack are set one cycle ahead so their registered
  // copies line up with the ISSUE and RESP cycles respectively.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    mul_start_d = 1'b0;
    timer_d     = timer_q;
    rsp_z_d     = rsp_z_q;
    rsp_err_d   = rsp_err_q;
    ack_d       = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          gidx_d      = gnt_idx_c;
          mul_x_d     = bus.req_x[32'(gnt_idx_c) * W +: W];
          mul_y_d     = bus.req_y[32'(gnt_idx_c) * W +: W];
          mul_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // timer_q == 0 marks the first WAIT cycle, where valid may be stale.
        if (timer_q != '0 && bus.mul_valid) begin
          rsp_z_d   = bus.mul_z;
          rsp_err_d = 1'b0;
          ack_d     = N'(1) << gidx_q;
          state_d   = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_z_d   = '0;
          rsp_err_d = 1'b1;
          ack_d     = N'(1) << gidx_q;
          state_d   = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.ack       = ack_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_x     = mul_x_q;
  assign bus.mul_y     = mul_y_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level reference and a latency-programmable
// behavioural multiplier.
module tb_booth_mul_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned W       = 4;
  localparam int unsigned TIMEOUT = 32;
  localparam int unsigned ZW      = 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mul_arbiter_if #(.N(N), .W(W)) bus ();

  booth_mul_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Requester-side state.
  logic [W-1:0] ox [N];
  logic [W-1:0] oy [N];
  bit           pend [N];
  bit           hold_all = 1'b0;
  bit           rand_req = 1'b0;
  bit           force_to = 1'b0;

  // Reference arbiter state (transaction level).
  int     cyc = 0, idle_cyc = 0, ptr = 0;
  bit     inflight = 1'b0, cur_to = 1'b0;
  int     cur = 0, ack_cyc = 0, start_cyc = 0, n_ops = 0;
  longint exp_z = 0, last_z = 0, last_err = 0;
  int     ack_log [$];

  // Behavioural multiplier state.
  int     mcnt = 0;
  bit     mjust = 1'b0, mto = 1'b0;
  longint mprod = 0;

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sz(input logic [ZW-1:0] v);
    return longint'($signed(v));
  endfunction

  // First pending requester at or after ptr, wrapping; -1 if none.
  function automatic int pick();
    for (int k = 0; k < int'(N); k++) begin
      int j;
      j = (ptr + k) % int'(N);
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  task automatic push_bus();
    for (int i = 0; i < int'(N); i++) begin
      bus.req[i]           = pend[i];
      bus.req_x[i*W +: W]  = ox[i];
      bus.req_y[i*W +: W]  = oy[i];
    end
  endtask

  // One clock: check outputs, advance models, drive the next inputs.
  task automatic step();
    logic [N-1:0] exp_ack;
    bit           exp_start;
    int           lat;
    @(negedge clk);
    cyc++;
    exp_start = !inflight && (cyc - 1 >= idle_cyc) && (pick() >= 0);
    check_eq("mul_start", longint'(bus.mul_start), longint'(exp_start));
    if (exp_start) begin
      cur = pick();
      check_eq("mul_x", sx(bus.mul_x), sx(ox[cur]));
      check_eq("mul_y", sx(bus.mul_y), sx(oy[cur]));
      inflight  = 1'b1;
      start_cyc = cyc;
      exp_z     = sx(ox[cur]) * sx(oy[cur]);
      cur_to    = force_to;
      lat       = int'($urandom_range(2, 2 * W + 2));
      ack_cyc   = cur_to ? cyc + int'(TIMEOUT) + 1 : cyc + lat + 1;
      mcnt      = lat;
      mjust     = 1'b1;
      mto       = cur_to;
      mprod     = exp_z;
      if ($urandom_range(0, 1) == 1) begin
        bus.mul_valid = 1'b1;
        bus.mul_z     = ZW'($urandom);
      end
    end else if (mcnt > 0) begin
      mcnt--;
      if (mjust) mjust = 1'b0;
      else if (mcnt == 0 && !mto) begin
        bus.mul_valid = 1'b1;
        bus.mul_z     = ZW'(mprod);
      end else bus.mul_valid = 1'b0;
    end

    check_eq("busy", longint'(bus.busy), longint'(inflight));
    exp_ack = (inflight && cyc == ack_cyc) ? (N'(1) << cur) : '0;
    check_eq("ack", longint'(bus.ack), longint'(exp_ack));
    if (inflight && cyc == ack_cyc) begin
      last_z   = sz(bus.rsp_z);
      last_err = longint'(bus.rsp_err);
      check_eq("rsp_z", last_z, cur_to ? 0 : exp_z);
      check_eq("rsp_err", last_err, longint'(cur_to));
      ack_log.push_back(cur);
      ptr      = (cur + 1) % int'(N);
      inflight = 1'b0;
      idle_cyc = cyc + 1;
      n_ops++;
      if (hold_all) begin
        ox[cur] = W'($urandom);
        oy[cur] = W'($urandom);
      end else pend[cur] = 1'b0;
    end

    if (rand_req) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          ox[i]   = W'($urandom);
          oy[i]   = W'($urandom);
        end else if (pend[i] && !(inflight && cur == i) && $urandom_range(0, 7) == 0) begin
          ox[i] = W'($urandom);
          oy[i] = W'($urandom);
        end
      end
    end
    push_bus();
  endtask

  task automatic wait_ops(input string tag, input int n, input int budget);
    int target, t;
    target = n_ops + n;
    t      = 0;
    while (n_ops < target && t < budget) begin
      step();
      t++;
    end
    check_eq(tag, longint'(n_ops - (target - n)), longint'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ack"},   longint'(bus.ack), 0);
    check_eq({tag, "_rsp_z"}, longint'(bus.rsp_z), 0);
    check_eq({tag, "_err"},   longint'(bus.rsp_err), 0);
    check_eq({tag, "_busy"},  longint'(bus.busy), 0);
    check_eq({tag, "_start"}, longint'(bus.mul_start), 0);
    check_eq({tag, "_mx"},    longint'(bus.mul_x), 0);
    check_eq({tag, "_my"},    longint'(bus.mul_y), 0);
  endtask

  // Assert reset just after a falling edge, check outputs, release a cycle later.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    inflight      = 1'b0;
    ptr           = 0;
    mcnt          = 0;
    mjust         = 1'b0;
    bus.mul_valid = 1'b0;
    bus.mul_z     = '0;
    @(negedge clk);
    cyc++;
    rst      = 1'b0;
    idle_cyc = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, npend;
    for (int i = 0; i < int'(N); i++) begin
      pend[i] = 1'b0;
      ox[i]   = '0;
      oy[i]   = '0;
    end
    bus.mul_valid = 1'b0;
    bus.mul_z     = '0;
    push_bus();
    @(negedge clk);
    do_reset("rst0");

    // Single requester, positive operands.
    pend[0] = 1'b1; ox[0] = 4'd5; oy[0] = 4'd7; push_bus();
    wait_ops("t1_done", 1, 60);
    check_eq("t1_idx", longint'(ack_log[$]), 0);
    check_eq("t1_z", last_z, 35);
    check_eq("t1_err", last_err, 0);

    // Signed operands.
    pend[1] = 1'b1; ox[1] = 4'hC; oy[1] = 4'd6; push_bus();
    wait_ops("t2a_done", 1, 60);
    check_eq("t2a_z", last_z, -24);
    pend[1] = 1'b1; ox[1] = 4'h8; oy[1] = 4'h8; push_bus();
    wait_ops("t2b_done", 1, 60);
    check_eq("t2b_z", last_z, 64);

    // Fairness with all four requesting continuously from a fresh reset.
    do_reset("rst1");
    hold_all = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      pend[i] = 1'b1; ox[i] = W'($urandom); oy[i] = W'($urandom);
    end
    push_bus();
    wait_ops("t3_done", 5, 120);
    begin
      int exp_order [5];
      exp_order = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++)
        check_eq($sformatf("t3_order%0d", k),
                 longint'(ack_log[ack_log.size() - 5 + k]), longint'(exp_order[k]));
    end
    hold_all = 1'b0;
    wait_ops("t3_drain", 4, 120);

    // Wrap-around from pointer 3: requester 3 before requester 0.
    pend[2] = 1'b1; push_bus();
    wait_ops("t4_pre", 1, 60);
    pend[0] = 1'b1; pend[3] = 1'b1; push_bus();
    wait_ops("t4_done", 2, 60);
    check_eq("t4_first", longint'(ack_log[ack_log.size() - 2]), 3);
    check_eq("t4_second", longint'(ack_log[ack_log.size() - 1]), 0);

    // Timeout, then a normal operation.
    force_to = 1'b1;
    pend[1] = 1'b1; ox[1] = 4'd3; oy[1] = 4'd3; push_bus();
    wait_ops("t5_done", 1, int'(TIMEOUT) + 20);
    check_eq("t5_err", last_err, 1);
    check_eq("t5_z", last_z, 0);
    force_to = 1'b0;
    pend[2] = 1'b1; ox[2] = 4'd7; oy[2] = 4'hF; push_bus();
    wait_ops("t5_next", 1, 60);
    check_eq("t5_next_err", last_err, 0);
    check_eq("t5_next_z", last_z, -7);

    // Reset while waiting on the multiplier; pointer must return to 0.
    pend[1] = 1'b1; push_bus();
    wait_ops("t6_pre", 1, 60);
    pend[3] = 1'b1; ox[3] = 4'd2; oy[3] = 4'd5; push_bus();
    t = 0;
    while (!(inflight && cyc == start_cyc + 2) && t < 60) begin
      step();
      t++;
    end
    check_eq("t6_reached_wait", longint'(inflight && cyc == start_cyc + 2), 1);
    do_reset("t6_rst");
    pend[1] = 1'b1; ox[1] = 4'hE; oy[1] = 4'd3; push_bus();
    wait_ops("t6_a", 1, 60);
    check_eq("t6_first", longint'(ack_log[$]), 1);
    check_eq("t6_first_z", last_z, -6);
    wait_ops("t6_b", 1, 60);
    check_eq("t6_second", longint'(ack_log[$]), 3);
    check_eq("t6_second_z", last_z, 10);

    // Random traffic with occasional timeouts.
    rand_req = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      force_to = ($urandom_range(0, 15) == 0);
      step();
    end
    rand_req = 1'b0;
    force_to = 1'b0;
    t = 0;
    npend = 1;
    while (npend != 0 && t < 2000) begin
      step();
      t++;
      npend = 0;
      for (int i = 0; i < int'(N); i++) npend += int'(pend[i]);
    end
    check_eq("drain", longint'(npend), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
